// File: rtl/seg_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package seg_pkg;
  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  localparam int unsigned DIV_DEF   = 100000;
  localparam int unsigned BLANK_DEF = 1000;

  function automatic nibble_t nib_at(
    input logic [31:0] v,
    input digit_idx_t  i
  );
    return v[{i, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     tick,
  output logic [$clog2(DIV)-1:0]   presc
);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  assign tick = enable && (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else if (enable)
      presc <= presc + PW'(1);
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller: shadowed value, refresh index, dead-time and
// leading-zero blanking for an 8-digit multiplexed display.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned BLANK = BLANK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] value,
  input  logic        value_load,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [2:0]  counter,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        blank,
  output logic        frame_start
);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW:0] BLK = (PW + 1)'(BLANK);

  logic          tick;
  logic [PW-1:0] presc;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick),
    .presc  (presc)
  );

  logic [31:0] stage;
  logic [31:0] shadow;
  logic        pending;

  logic          wrap;
  digit_idx_t    cnt_n;
  logic [31:0]   shadow_n;
  logic [PW-1:0] presc_n;
  logic          dead_n;
  logic [7:0]    lzm;
  logic          seen;
  logic          blank_n;

  assign wrap     = tick && (counter == 3'd7);
  assign cnt_n    = tick ? counter + 3'd1 : counter;
  assign shadow_n = (wrap && pending) ? stage : shadow;

  // Outputs are registered from next-state so they line up with counter.
  always_comb begin
    presc_n = presc;
    if (tick)
      presc_n = '0;
    else if (enable)
      presc_n = presc + PW'(1);
    dead_n = {1'b0, presc_n} < BLK;
  end

  always_comb begin
    lzm  = '0;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      seen   = seen | (shadow_n[4*i +: 4] != 4'h0);
      lzm[i] = !seen;
    end
  end

  assign blank_n = !enable || dead_n
                || (blank_lz && lzm[cnt_n]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      stage   <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      counter <= cnt_n;
      shadow  <= shadow_n;
      if (value_load) begin
        stage   <= value;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit       <= '0;
      dp          <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      digit       <= nib_at(shadow_n, cnt_n);
      dp          <= !blank_n && dp_mask[cnt_n];
      blank       <= blank_n;
      frame_start <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-arithmetic model.
module tb_seg_scan_ctrl;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] value;
  logic        value_load;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [2:0]  counter;
  logic [3:0]  digit;
  logic        dp;
  logic        blank;
  logic        frame_start;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value       (value),
    .value_load  (value_load),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .counter     (counter),
    .digit       (digit),
    .dp          (dp),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Model: t = enabled cycles since reset; slot = t/DIV, phase = t%DIV.
  int          t;
  logic [31:0] m_stage, m_shadow;
  bit          m_pend, m_fs, m_en, m_lz;
  logic [7:0]  m_dpm;

  function automatic void m_reset();
    t = 0; m_stage = 0; m_shadow = 0;
    m_pend = 0; m_fs = 0; m_en = 0;
    m_lz = 0; m_dpm = 0;
  endfunction

  function automatic void m_step();
    bit w;
    w = enable && (t % FRAME == FRAME - 1);
    if (enable) t = (t + 1) % FRAME;
    m_fs = w;
    if (w && m_pend) begin
      m_shadow = m_stage;
      m_pend = 0;
    end
    if (value_load) begin
      m_stage = value;
      m_pend = 1;
    end
    m_en = enable; m_lz = blank_lz; m_dpm = dp_mask;
  endfunction

  task automatic check_all();
    int c, p;
    bit supp, b;
    c = t / DIV;
    p = t % DIV;
    supp = m_lz && c != 0 && (m_shadow >> (4 * c)) == 0;
    b = !m_en || p < BLANK || supp;
    chk("counter", 32'(counter), 32'(c));
    chk("digit", 32'(digit), (m_shadow >> (4 * c)) & 32'hF);
    chk("blank", 32'(blank), 32'(b));
    chk("dp", 32'(dp), 32'(!b && m_dpm[c]));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [31:0] v);
    value = v; value_load = 1'b1;
    cycle();
    value_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; value = '0;
    value_load = 1'b0; dp_mask = '0; blank_lz = 1'b0;
    m_reset();
    #1;
    check_all();
    #12;
    check_all();
    rst = 1'b0;

    // Scan with a known value, then tear-free mid-frame update.
    load(32'h87654321);
    run(2 * FRAME);
    run(13);
    load(32'h11111111);
    run(2 * FRAME);

    // Leading zeros and decimal point.
    blank_lz = 1'b1; dp_mask = 8'h04;
    load(32'h00000A05);
    run(2 * FRAME);
    load(32'h0);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Enable hold at slot 5, phase 2.
    for (int k = 0; k < FRAME && t != 5 * DIV + 2; k++) cycle();
    chk("hold_pos", 32'(t), 32'(5 * DIV + 2));
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(DIV);

    // Load landing exactly on the wrap while an older load is pending.
    for (int k = 0; k < FRAME && t != 0; k++) cycle();
    load(32'h22222222);
    for (int k = 0; k < FRAME && t != FRAME - 1; k++) cycle();
    chk("wrap_pos", 32'(t), 32'(FRAME - 1));
    load(32'hFFFFFFFF);
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 16) != 0;
      value_load = ($urandom % 12) == 0;
      value = $urandom >> ($urandom % 33);
      if ($urandom % 20 == 0) blank_lz = $urandom;
      if ($urandom % 10 == 0) dp_mask = $urandom;
      cycle();
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all();
        #2 rst = 1'b0;
      end
    end
    value_load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
